// File: rtl/fetch_unit_pkg.sv
// Shared SimpleRISC fetch definitions: hlt opcode, NOP encoding and fetch FSM state encodings.
package fetch_unit_pkg;

  localparam logic [4:0]  HLT_OPCODE = 5'b11111;
  localparam logic [31:0] NOP_INST   = 32'h6800_0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_perf_ctr.sv
// Fetch performance counters: captured instructions and RUN-state stall cycles, both wrapping at 2^32.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (fetch_inc_i ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + (stall_inc_i ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// SimpleRISC IF stage: PC, 1-cycle instruction memory addressing and the IF/OF pipeline register.
// Optional macro FETCH_PERF_CNT_EN adds fetch/stall counters (fetch_cnt_o, stall_cnt_o).
//
// state   | meaning
// BOOT    | first cycle after reset; primes memory latency with pc
// RUN     | normal fetch; im_data_i holds instr(pc)
// HALTED  | hlt captured; fetch frozen until a branch redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          IM_ADDR_W = 7,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 branch_taken_i,
  input  logic [31:0]          branch_pc_i,
  output logic [IM_ADDR_W-1:0] im_addr_o,
  input  logic [31:0]          im_data_i,
  output logic [31:0]          if_of_pc_o,
  output logic [31:0]          if_of_inst_o,
  output logic                 if_of_valid_o,
  output logic                 halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_of_pc_q, if_of_pc_d;
  logic [31:0]  if_of_inst_q, if_of_inst_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         capture;
  logic [31:0]  branch_pc_aligned;
  logic         unused_branch_lsbs;

  // Redirect targets are always forced to word alignment.
  assign branch_pc_aligned  = {branch_pc_i[31:2], 2'b00};
  assign unused_branch_lsbs = ^branch_pc_i[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_of_pc_d   = if_of_pc_q;
    if_of_inst_d = if_of_inst_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    capture      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        valid_d = 1'b0;
        state_d = ST_RUN;
        if (branch_taken_i) pc_d = branch_pc_aligned;
      end
      ST_RUN: begin
        if (branch_taken_i) begin
          pc_d    = branch_pc_aligned;
          valid_d = 1'b0;
        end else if (!stall_i) begin
          capture      = 1'b1;
          if_of_inst_d = im_data_i;
          if_of_pc_d   = pc_q;
          valid_d      = 1'b1;
          if (im_data_i[31:27] == HLT_OPCODE) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      ST_HALTED: begin
        valid_d = 1'b0;
        if (branch_taken_i) begin
          pc_d     = branch_pc_aligned;
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      if_of_pc_q   <= '0;
      if_of_inst_q <= NOP_INST;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_of_pc_q   <= if_of_pc_d;
      if_of_inst_q <= if_of_inst_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
    end
  end

  assign im_addr_o     = pc_d[IM_ADDR_W+1:2];
  assign if_of_pc_o    = if_of_pc_q;
  assign if_of_inst_o  = if_of_inst_q;
  assign if_of_valid_o = valid_q;
  assign halted_o      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic stall_inc;
  assign stall_inc = (state_q == ST_RUN) && stall_i && !branch_taken_i;

  fetch_perf_ctr u_perf (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc_i (capture),
    .stall_inc_i (stall_inc),
    .fetch_cnt_o (fetch_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a 1-cycle-latency instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_pc_i;
  logic [6:0]  im_addr_o;
  logic [31:0] im_data_i;
  logic [31:0] if_of_pc_o;
  logic [31:0] if_of_inst_o;
  logic        if_of_valid_o;
  logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [128];

  localparam logic [31:0] NOP = 32'h6800_0000;
  localparam logic [31:0] HLT = 32'hF800_0000;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_pc_i    (branch_pc_i),
    .im_addr_o      (im_addr_o),
    .im_data_i      (im_data_i),
    .if_of_pc_o     (if_of_pc_o),
    .if_of_inst_o   (if_of_inst_o),
    .if_of_valid_o  (if_of_valid_o),
    .halted_o       (halted_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o    (fetch_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) im_data_i <= mem[im_addr_o];

  function automatic logic [31:0] w(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, check im_addr before the edge, then registered outputs after it.
  task automatic step(input logic s, input logic b, input logic [31:0] bpc,
                      input logic [6:0] ea, input logic ev, input logic [31:0] epc,
                      input logic [31:0] einst, input logic eh, input string tag);
    stall_i        = s;
    branch_taken_i = b;
    branch_pc_i    = bpc;
    #1;
    chk({tag, " im_addr"}, 32'(im_addr_o), 32'(ea));
    @(posedge clk);
    #1;
    chk({tag, " valid"},  32'(if_of_valid_o), 32'(ev));
    chk({tag, " pc"},     if_of_pc_o, epc);
    chk({tag, " inst"},   if_of_inst_o, einst);
    chk({tag, " halted"}, 32'(halted_o), 32'(eh));
    @(negedge clk);
    stall_i        = 1'b0;
    branch_taken_i = 1'b0;
    branch_pc_i    = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rst valid"},  32'(if_of_valid_o), 32'd0);
    chk({tag, " rst pc"},     if_of_pc_o, 32'd0);
    chk({tag, " rst inst"},   if_of_inst_o, NOP);
    chk({tag, " rst halted"}, 32'(halted_o), 32'd0);
    chk({tag, " rst addr"},   32'(im_addr_o), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, " rst fetch_cnt"}, fetch_cnt_o, 32'd0);
    chk({tag, " rst stall_cnt"}, stall_cnt_o, 32'd0);
`endif
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bpc;
    logic [6:0]  addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst            = 1'b1;
    stall_i        = 1'b0;
    branch_taken_i = 1'b0;
    branch_pc_i    = '0;
    for (int i = 0; i < 128; i++) mem[i] = w(i);

    // Boot, sequential fetch, 3-cycle stall, branch-over-stall, stall during bubble, PC wrap.
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd0,   1'b0, 32'h0,         NOP});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd1,   1'b1, 32'h0,         w(0)});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd2,   1'b1, 32'h4,         w(1)});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         7'd2,   1'b1, 32'h4,         w(1)});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         7'd2,   1'b1, 32'h4,         w(1)});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         7'd2,   1'b1, 32'h4,         w(1)});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd3,   1'b1, 32'h8,         w(2)});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd4,   1'b1, 32'hC,         w(3)});
    vecs.push_back('{1'b1, 1'b1, 32'h43,        7'd16,  1'b0, 32'hC,         w(3)});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd17,  1'b1, 32'h40,        w(16)});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd18,  1'b1, 32'h44,        w(17)});
    vecs.push_back('{1'b0, 1'b1, 32'h10,        7'd4,   1'b0, 32'h44,        w(17)});
    vecs.push_back('{1'b1, 1'b0, 32'h0,         7'd4,   1'b0, 32'h44,        w(17)});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd5,   1'b1, 32'h10,        w(4)});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFF_FFFC, 7'd127, 1'b0, 32'h10,        w(4)});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd0,   1'b1, 32'hFFFF_FFFC, w(127)});
    vecs.push_back('{1'b0, 1'b0, 32'h0,         7'd1,   1'b1, 32'h0,         w(0)});

    repeat (2) @(negedge clk);
    chk_reset("init");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].stall, vecs[i].br, vecs[i].bpc, vecs[i].addr, vecs[i].valid,
           vecs[i].pc, vecs[i].inst, 1'b0, $sformatf("vec%0d", i));

`ifdef FETCH_PERF_CNT_EN
    chk("tbl fetch_cnt", fetch_cnt_o, 32'd9);
    chk("tbl stall_cnt", stall_cnt_o, 32'd4);
`endif

    // Mid-stream reset takes effect without a clock edge.
    rst = 1'b1;
    #1;
    chk_reset("mid");

    // hlt at word 5: captured valid, then frozen until a redirect.
    mem[5] = HLT;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0, NOP, 1'b0, "hboot");
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 32'h0, 7'(k + 1), 1'b1, 32'(4 * k), w(k), 1'b0, $sformatf("hseq%0d", k));
    step(1'b0, 1'b0, 32'h0, 7'd5, 1'b1, 32'd20, HLT, 1'b1, "hcap");
    for (int k = 0; k < 4; k++)
      step(k[0], 1'b0, 32'h0, 7'd5, 1'b0, 32'd20, HLT, 1'b1, $sformatf("hfrz%0d", k));
    step(1'b0, 1'b1, 32'h0, 7'd0, 1'b0, 32'd20, HLT, 1'b0, "hbr");
    step(1'b0, 1'b0, 32'h0, 7'd1, 1'b1, 32'h0, w(0), 1'b0, "hres");

`ifdef FETCH_PERF_CNT_EN
    chk("hlt fetch_cnt", fetch_cnt_o, 32'd7);
    chk("hlt stall_cnt", stall_cnt_o, 32'd0);
`endif

    // Redirect taken in the BOOT cycle.
    rst = 1'b1;
    #1;
    chk_reset("boot");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 32'h20, 7'd8, 1'b0, 32'h0,  NOP,  1'b0, "bbr");
    step(1'b0, 1'b0, 32'h0,  7'd9, 1'b1, 32'h20, w(8), 1'b0, "bcap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
